// File: rtl/bus_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package bus_pkg;

   localparam int BUS_DATA_WIDTH_DEF = 64;
   localparam int BUS_TAG_WIDTH_DEF  = 13;
   localparam int BURST_BEATS_DEF    = 8;

   // Top tag bit marks a write transaction.
   function automatic int write_bit(input int tag_w);
      return tag_w - 1;
   endfunction

   localparam int WRITE_BIT = write_bit(BUS_TAG_WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      WDATA = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One tagged request/response bus channel. The master drives requests and
// consumes responses; the slave accepts requests and produces responses.
interface mem_bus_if #(
   parameter int DW = 64,
   parameter int TW = 13
);
   logic          reqcyc;
   logic [DW-1:0] req;
   logic [TW-1:0] reqtag;
   logic          reqack;
   logic          respcyc;
   logic [DW-1:0] resp;
   logic [TW-1:0] resptag;
   logic          respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker2.sv
// Two-way round-robin choice: on a tie the port not granted last wins.
module rr_picker2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic winner
);
   // Lone requester wins outright; a tie alternates away from last.
   always_comb begin
      winner = req1;
      if (req0 && req1) winner = ~last;
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one tagged memory bus between the instruction cache (m0) and the
// data cache (m1). A grant is held for the address beat, any write-data
// beats and the full read response burst.
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
   parameter int BUS_TAG_WIDTH  = BUS_TAG_WIDTH_DEF,
   parameter int BURST_BEATS    = BURST_BEATS_DEF
) (
   input  logic      clk,
   input  logic      reset,
   mem_bus_if.slave  m0,
   mem_bus_if.slave  m1,
   mem_bus_if.master bus
);

   localparam int CW   = $clog2(BURST_BEATS) + 1;
   localparam int WBIT = write_bit(BUS_TAG_WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(BURST_BEATS);

   arb_state_t state, state_nxt;
   logic          gnt, gnt_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] cnt_inc;
   logic          pick;

   logic                      g_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] g_req;
   logic [BUS_TAG_WIDTH-1:0]  g_reqtag;
   logic                      g_respack;

   rr_picker2 u_pick (
      .req0   (m0.reqcyc),
      .req1   (m1.reqcyc),
      .last   (last),
      .winner (pick)
   );

   // Request-side view of whichever port currently owns the bus.
   always_comb begin
      g_reqcyc  = gnt ? m1.reqcyc  : m0.reqcyc;
      g_req     = gnt ? m1.req     : m0.req;
      g_reqtag  = gnt ? m1.reqtag  : m0.reqtag;
      g_respack = gnt ? m1.respack : m0.respack;
      cnt_inc   = cnt + 1'b1;
   end

   // State, owner, fairness history and beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and routing; everything stays 0 in IDLE and while in reset.
   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      last_nxt    = last;
      cnt_nxt     = cnt;
      bus.reqcyc  = 1'b0;
      bus.req     = '0;
      bus.reqtag  = '0;
      bus.respack = 1'b0;
      m0.reqack   = 1'b0;
      m0.respcyc  = 1'b0;
      m0.resp     = '0;
      m0.resptag  = '0;
      m1.reqack   = 1'b0;
      m1.respcyc  = 1'b0;
      m1.resp     = '0;
      m1.resptag  = '0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               // Decision cycle only; the bus is driven from ADDR onwards.
               if (m0.reqcyc || m1.reqcyc) begin
                  gnt_nxt   = pick;
                  state_nxt = ADDR;
               end
            end
            ADDR, WDATA: begin
               bus.reqcyc = g_reqcyc;
               bus.req    = g_req;
               bus.reqtag = g_reqtag;
               if (gnt) m1.reqack = bus.reqack;
               else     m0.reqack = bus.reqack;
               if (state == ADDR) begin
                  if (!g_reqcyc) begin
                     // Requester withdrew before the address was taken.
                     state_nxt = IDLE;
                     last_nxt  = gnt;
                  end else if (bus.reqack) begin
                     state_nxt = g_reqtag[WBIT] ? WDATA : RESP;
                     cnt_nxt   = '0;
                  end
               end else if (g_reqcyc && bus.reqack) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == LAST_CNT) begin
                     state_nxt = IDLE;
                     last_nxt  = gnt;
                  end
               end
            end
            RESP: begin
               bus.respack = g_respack;
               if (gnt) begin
                  m1.respcyc = bus.respcyc;
                  m1.resp    = bus.resp;
                  m1.resptag = bus.resptag;
               end else begin
                  m0.respcyc = bus.respcyc;
                  m0.resp    = bus.resp;
                  m0.resptag = bus.resptag;
               end
               // A beat the requester does not accept stalls the burst.
               if (bus.respcyc && g_respack) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == LAST_CNT) begin
                     state_nxt = IDLE;
                     last_nxt  = gnt;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 64-bit tagged memory bus between two requesters: port 0 is the instruction cache and port 1 is the data cache.
- Grants the bus to one requester at a time and holds the grant for the whole transaction: the address beat, any write-data beats, and the read response burst.
- Forwards the granted requester's handshakes to and from the bus.
- Sits between the cache layer and the top-level bus pins.

Parameters:
- BUS_DATA_WIDTH, 64, width of the req/resp data bus.
- BUS_TAG_WIDTH, 13, width of the req/resp tag; bit BUS_TAG_WIDTH-1 of reqtag set means a write.
- BURST_BEATS, 8, data beats per line transfer, for both read responses and write data.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_reqcyc  in  1  instruction-cache request valid
- m0_req  in  BUS_DATA_WIDTH  instruction-cache address/data
- m0_reqtag  in  BUS_TAG_WIDTH  instruction-cache tag
- m0_reqack  out  1  request beat accepted, to instruction cache
- m0_respcyc  out  1  response beat valid, to instruction cache
- m0_resp  out  BUS_DATA_WIDTH  response data
- m0_resptag  out  BUS_TAG_WIDTH  response tag
- m0_respack  in  1  instruction cache consumed beat
- m1_*  same set as m0_*, for the data cache
- bus_reqcyc  out  1  request to memory
- bus_req  out  BUS_DATA_WIDTH  request data
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_reqack  in  1  memory accepted request beat
- bus_respcyc  in  1  memory response beat valid
- bus_resp  in  BUS_DATA_WIDTH  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag
- bus_respack  out  1  response beat consumed

Behaviour:
- Clock is clk; reset is reset, synchronous, active-high.
- States:
  - IDLE
  - ADDR: address beat outstanding
  - WDATA: write data beats
  - RESP: read response beats
- Registers:
  - gnt: 0 or 1, the current owner
  - last: the last port granted; reset value 0, so port 1 wins the first tie
  - beat counter: $clog2(BURST_BEATS)+1 bits
- Reset, or reset asserted in any state: state goes to IDLE, counter to 0, last to 0. All outputs are 0 while in IDLE and during reset.
- IDLE:
  - Only one mX_reqcyc high: grant that port.
  - Both high: grant the port that is not last (round-robin).
  - Neither high: stay in IDLE.
  - Latch gnt and go to ADDR on the next edge. Grant latency is 1 cycle, and no bus output is driven in the decision cycle.
- ADDR / WDATA:
  - bus_reqcyc, bus_req and bus_reqtag are combinational pass-throughs of the granted port.
  - The granted port's reqack equals bus_reqack. The non-granted reqack is 0.
- ADDR transitions:
  - On bus_reqack, with write bit set: go to WDATA, counter = 0.
  - On bus_reqack, with write bit clear: go to RESP, counter = 0.
  - Granted reqcyc drops before the ack: abort to IDLE and set last = gnt.
- WDATA: each beat with reqcyc & reqack increments the counter. When the counter reaches BURST_BEATS, go to IDLE and set last = gnt. Writes have no response phase.
- RESP:
  - The granted port's respcyc, resp and resptag mirror the bus.
  - bus_respack equals the granted port's respack.
  - Each beat with respcyc & respack increments the counter. After the BURST_BEATS-th beat, go to IDLE and set last = gnt.
- The non-granted port always sees respcyc = 0 and reqack = 0. Its reqcyc stays pending, with no timeout.
- bus_respcyc in IDLE, ADDR or WDATA is not routed: bus_respack = 0 and the beat is dropped.
- A beat where respcyc is high but respack is low does not count; the requester stalls the burst.
- Back-to-back transactions: at least one IDLE cycle between them, so the minimum transaction gap is 1 cycle.

Decomposition:
- Shared package bus_pkg holds:
  - the state enum arb_state_t
  - the WRITE_BIT index (BUS_TAG_WIDTH-1)
  - the BURST_BEATS default
- Sub-module rr_picker2: combinational two-way round-robin choice from (req0, req1, last), returning the winner index.
- Everything else stays inline.

Test Plan:
- Single read on m0 (addr 0x1000, tag 0x001): bus_reqcyc is seen 1 cycle after m0_reqcyc. After 8 acked beats the state returns to IDLE, m0 receives all 8 data words in order, and m1_respcyc stays 0 throughout.
- Simultaneous m0 and m1 reads just after reset: m1 is served first. m0 is then granted on the cycle after m1's 8th beat plus 1 IDLE cycle, and last=0 afterwards.
- m1 write (tag 0x1005): address plus 8 data beats acked, no RESP state entered, and bus_respack stays 0 for a spurious bus_respcyc pulse injected during WDATA.
- m0 respack held low for 3 cycles mid-burst: the count does not advance, and exactly 8 beats are delivered in total.
- Reset asserted during beat 4 of a read: the next cycle is IDLE, all outputs are 0, and a fresh m0 request is granted normally.
- m1 drops reqcyc in ADDR before bus_reqack: the arbiter returns to IDLE and a pending m0 request is granted next.
